uart_rx_param: RTL and testbench

Parametrised UART receiver, the successor to the fixed-format receive path in the UART core. It handles configurable data width, stop-bit count and oversampling ratio, and a runtime-selectable parity mode (none/even/odd). It reports break, parity, frame and overrun conditions and presents each received word through a ready/pop handshake to the receive FIFO or the BIST block.

---
 rtl/uart_rx_param.sv | 222 ++++++++++++++++++++++
 tb/tb_uart_rx_param.sv | 441 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: configurable data width, stop bits and
// oversampling, runtime parity mode, break/parity/frame/overrun reporting,
// and a ready/pop handshake towards the consumer.
module uart_rx_param #(
  parameter int unsigned SYSCLK_RATE = 100000000,
  parameter int unsigned BAUD_RATE   = 9600,
  parameter int unsigned DATA_BITS   = 8,
  parameter int unsigned STOP_BITS   = 2,
  parameter int unsigned OVERSAMPLE  = 16
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 Rx_En,
  input  logic                 Rx,
  input  logic [1:0]           Parity_Mode,
  input  logic                 Pop_Data,
  output logic [DATA_BITS-1:0] Data_Out,
  output logic                 Data_Rdy,
  output logic [2:0]           Rx_Error,
  output logic                 Overrun,
  output logic                 Rx_Busy
);

  localparam int unsigned DIV_RAW = SYSCLK_RATE / (BAUD_RATE * OVERSAMPLE);
  localparam int unsigned DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int unsigned DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned TICK_W  = $clog2(OVERSAMPLE);
  localparam int unsigned BIT_W   = $clog2(DATA_BITS);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK_WAIT
  } state_e;

  state_e               state_q, state_d;
  logic                 rx_meta_q, rx_meta_d;
  logic                 rx_s_q, rx_s_d;
  logic [DIV_W-1:0]     div_cnt_q, div_cnt_d;
  logic [TICK_W-1:0]    tick_cnt_q, tick_cnt_d;
  logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic                 stop_cnt_q, stop_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [1:0]           mode_q, mode_d;
  logic                 all_zero_q, all_zero_d;
  logic                 par_err_q, par_err_d;
  logic                 frame_err_q, frame_err_d;
  logic [DATA_BITS-1:0] data_out_q, data_out_d;
  logic                 data_rdy_q, data_rdy_d;
  logic [2:0]           rx_error_q, rx_error_d;
  logic                 overrun_q, overrun_d;
  logic                 busy_q, busy_d;

  logic tick, mid_start, mid_bit, par_en, par_exp;

  // Sample tick and mid-point strobes for the start bit and full bits
  assign tick      = (div_cnt_q == DIV_W'(DIV - 1));
  assign mid_start = tick && (tick_cnt_q == TICK_W'(OVERSAMPLE / 2 - 1));
  assign mid_bit   = tick && (tick_cnt_q == TICK_W'(OVERSAMPLE - 1));
  assign par_en    = (mode_q == 2'b01) || (mode_q == 2'b10);
  assign par_exp   = (^shift_q) ^ (mode_q == 2'b10);

  // Next-state, datapath and handshake logic
  always_comb begin
    logic                 frame_done;
    logic                 brk_now;
    logic [DATA_BITS-1:0] done_word;
    logic [2:0]           done_err;

    state_d     = state_q;
    rx_meta_d   = Rx;
    rx_s_d      = rx_meta_q;
    div_cnt_d   = tick ? '0 : div_cnt_q + DIV_W'(1);
    tick_cnt_d  = tick_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    stop_cnt_d  = stop_cnt_q;
    shift_d     = shift_q;
    mode_d      = mode_q;
    all_zero_d  = all_zero_q;
    par_err_d   = par_err_q;
    frame_err_d = frame_err_q;
    data_out_d  = data_out_q;
    data_rdy_d  = data_rdy_q;
    rx_error_d  = rx_error_q;
    overrun_d   = overrun_q;
    frame_done  = 1'b0;
    brk_now     = 1'b0;
    done_word   = '0;
    done_err    = '0;

    if (Pop_Data && data_rdy_q) begin
      data_rdy_d = 1'b0;
      overrun_d  = 1'b0;
    end

    if (state_q == S_IDLE) begin
      if (Rx_En && !rx_s_q) begin
        state_d     = S_START;
        div_cnt_d   = '0;
        tick_cnt_d  = '0;
        bit_cnt_d   = '0;
        stop_cnt_d  = 1'b0;
        all_zero_d  = 1'b1;
        par_err_d   = 1'b0;
        frame_err_d = 1'b0;
        mode_d      = Parity_Mode;
      end
    end else if (!Rx_En) begin
      state_d = S_IDLE;
    end else begin
      if (tick) tick_cnt_d = tick_cnt_q + TICK_W'(1);
      case (state_q)
        S_START: begin
          if (mid_start) begin
            tick_cnt_d = '0;
            state_d    = rx_s_q ? S_IDLE : S_DATA;
          end
        end
        S_DATA: begin
          if (mid_bit) begin
            tick_cnt_d = '0;
            shift_d    = {shift_q[DATA_BITS-2:0], rx_s_q};
            if (rx_s_q) all_zero_d = 1'b0;
            if (bit_cnt_q == BIT_W'(DATA_BITS - 1)) begin
              bit_cnt_d = '0;
              state_d   = par_en ? S_PARITY : S_STOP;
            end else begin
              bit_cnt_d = bit_cnt_q + BIT_W'(1);
            end
          end
        end
        S_PARITY: begin
          if (mid_bit) begin
            tick_cnt_d = '0;
            par_err_d  = (rx_s_q != par_exp);
            if (rx_s_q) all_zero_d = 1'b0;
            state_d    = S_STOP;
          end
        end
        S_STOP: begin
          if (mid_bit) begin
            tick_cnt_d = '0;
            if (rx_s_q) all_zero_d = 1'b0;
            else        frame_err_d = 1'b1;
            if (stop_cnt_q == 1'(STOP_BITS - 1)) begin
              brk_now    = all_zero_q && !rx_s_q;
              frame_done = 1'b1;
              done_word  = brk_now ? '0 : shift_q;
              done_err   = brk_now ? 3'b001 : {frame_err_q | ~rx_s_q, par_err_q, 1'b0};
              state_d    = brk_now ? S_BREAK_WAIT : S_IDLE;
            end else begin
              stop_cnt_d = 1'b1;
            end
          end
        end
        S_BREAK_WAIT: begin
          if (rx_s_q) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end

    // A completed frame is dropped when the previous word is still unclaimed
    if (frame_done) begin
      if (data_rdy_q && !Pop_Data) begin
        overrun_d = 1'b1;
      end else begin
        data_out_d = done_word;
        rx_error_d = done_err;
        data_rdy_d = 1'b1;
      end
    end

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q     <= S_IDLE;
      rx_meta_q   <= 1'b1;
      rx_s_q      <= 1'b1;
      div_cnt_q   <= '0;
      tick_cnt_q  <= '0;
      bit_cnt_q   <= '0;
      stop_cnt_q  <= 1'b0;
      shift_q     <= '0;
      mode_q      <= 2'b00;
      all_zero_q  <= 1'b0;
      par_err_q   <= 1'b0;
      frame_err_q <= 1'b0;
      data_out_q  <= '0;
      data_rdy_q  <= 1'b0;
      rx_error_q  <= 3'b000;
      overrun_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rx_meta_q   <= rx_meta_d;
      rx_s_q      <= rx_s_d;
      div_cnt_q   <= div_cnt_d;
      tick_cnt_q  <= tick_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      stop_cnt_q  <= stop_cnt_d;
      shift_q     <= shift_d;
      mode_q      <= mode_d;
      all_zero_q  <= all_zero_d;
      par_err_q   <= par_err_d;
      frame_err_q <= frame_err_d;
      data_out_q  <= data_out_d;
      data_rdy_q  <= data_rdy_d;
      rx_error_q  <= rx_error_d;
      overrun_q   <= overrun_d;
      busy_q      <= busy_d;
    end
  end

  assign Data_Out = data_out_q;
  assign Data_Rdy = data_rdy_q;
  assign Rx_Error = rx_error_q;
  assign Overrun  = overrun_q;
  assign Rx_Busy  = busy_q;

endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: line-level frame driver, line-waveform decoder as
// reference, and a handshake model for Data_Rdy / Overrun.
module tb_uart_rx_param;

  localparam int BIT_CLKS = 16;

  logic       Clk = 1'b0;
  logic       Rst = 1'b1;
  logic       Rx_En = 1'b0;
  logic       Rx = 1'b1;
  logic [1:0] Parity_Mode = 2'b00;
  logic       Pop_Data = 1'b0;
  logic [7:0] Data_Out;
  logic       Data_Rdy;
  logic [2:0] Rx_Error;
  logic       Overrun;
  logic       Rx_Busy;

  int checks = 0;
  int errors = 0;

  int   cyc = 0;
  int   rise_cyc = -1;
  logic rdy_prev = 1'b0;
  int   frame_start = 0;
  int   comp_lat = 0;

  bit line_bits [0:15];
  int line_len = 0;

  logic [7:0] exp_out = '0;
  logic [2:0] exp_err = '0;
  logic       exp_rdy = 1'b0;
  logic       exp_ovr = 1'b0;

  uart_rx_param #(
    .SYSCLK_RATE(1600), .BAUD_RATE(100), .DATA_BITS(8), .STOP_BITS(2), .OVERSAMPLE(16)
  ) dut (
    .Clk(Clk), .Rst(Rst), .Rx_En(Rx_En), .Rx(Rx), .Parity_Mode(Parity_Mode),
    .Pop_Data(Pop_Data), .Data_Out(Data_Out), .Data_Rdy(Data_Rdy),
    .Rx_Error(Rx_Error), .Overrun(Overrun), .Rx_Busy(Rx_Busy)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk) cyc <= cyc + 1;

  // Remember the cycle on which Data_Rdy last rose
  always @(negedge Clk) begin
    if (Data_Rdy && !rdy_prev) rise_cyc = cyc;
    rdy_prev = Data_Rdy;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  // Reference: decode the waveform that was put on the line
  function automatic logic [10:0] decode_line(input logic [1:0] mode);
    logic [7:0] d;
    logic brk, pe, fe;
    int idx;
    brk = 1'b1;
    for (int i = 0; i < line_len; i++) if (line_bits[i]) brk = 1'b0;
    d = '0;
    for (int i = 1; i <= 8; i++) d = {d[6:0], line_bits[i]};
    idx = 9;
    pe  = 1'b0;
    if (mode == 2'b01 || mode == 2'b10) begin
      pe  = (line_bits[9] != ((^d) ^ (mode == 2'b10)));
      idx = 10;
    end
    fe = 1'b0;
    for (int i = idx; i < line_len; i++) if (!line_bits[i]) fe = 1'b1;
    if (brk) return {3'b001, 8'h00};
    return {fe, pe, 1'b0, d};
  endfunction

  task automatic model_complete(input logic [10:0] r);
    if (exp_rdy) exp_ovr = 1'b1;
    else begin
      exp_err = r[10:8];
      exp_out = r[7:0];
      exp_rdy = 1'b1;
    end
  endtask

  task automatic model_pop();
    if (exp_rdy) begin
      exp_rdy = 1'b0;
      exp_ovr = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge Clk);
  endtask

  task automatic do_pop();
    @(negedge Clk); Pop_Data = 1'b1;
    @(negedge Clk); Pop_Data = 1'b0;
    model_pop();
  endtask

  // Drive one frame; optionally abort at bit abort_bit by reset or by Rx_En drop
  task automatic send_frame(input logic [7:0] d, input logic [1:0] mode, input bit flip,
                            input logic [1:0] stops, input int abort_bit, input bit abort_rst);
    bit pen;
    pen = (mode == 2'b01) || (mode == 2'b10);
    line_len = 0;
    line_bits[line_len] = 1'b0; line_len++;
    for (int i = 7; i >= 0; i--) begin line_bits[line_len] = d[i]; line_len++; end
    if (pen) begin line_bits[line_len] = (^d) ^ (mode == 2'b10) ^ flip; line_len++; end
    line_bits[line_len] = stops[1]; line_len++;
    line_bits[line_len] = stops[0]; line_len++;
    @(negedge Clk);
    Parity_Mode = mode;
    frame_start = cyc;
    for (int i = 0; i < line_len; i++) begin
      if (i == abort_bit) begin
        if (abort_rst) begin
          Rst = 1'b1; Rx = 1'b1;
          repeat (2) @(negedge Clk);
          Rst = 1'b0;
          break;
        end else begin
          Rx_En = 1'b0;
        end
      end
      Rx = line_bits[i];
      repeat (BIT_CLKS) @(negedge Clk);
    end
    Rx = 1'b1;
  endtask

  task automatic test_reset();
    Rst = 1'b1; Rx = 1'b1; Rx_En = 1'b0; Pop_Data = 1'b0; Parity_Mode = 2'b00;
    idle(3);
    if ({Data_Rdy, Overrun, Rx_Error, Data_Out, Rx_Busy} !== 14'd0) begin
      errors++;
      $display("FAIL reset_values: got rdy=%b ovr=%b err=%b data=%h busy=%b, want all zero",
               Data_Rdy, Overrun, Rx_Error, Data_Out, Rx_Busy);
    end
    checks++;
    Rst = 1'b0; Rx_En = 1'b1;
    idle(6);
    if ({Data_Rdy, Overrun, Rx_Error, Data_Out, Rx_Busy} !== 14'd0) begin
      errors++;
      $display("FAIL reset_release: got rdy=%b ovr=%b err=%b data=%h busy=%b, want all zero",
               Data_Rdy, Overrun, Rx_Error, Data_Out, Rx_Busy);
    end
    checks++;
  endtask

  task automatic test_even_parity();
    int lat, mid;
    rise_cyc = -1;
    send_frame(8'hA5, 2'b01, 1'b0, 2'b11, -1, 1'b0);
    model_complete(decode_line(2'b01));
    lat = rise_cyc - frame_start;
    mid = (line_len - 1) * BIT_CLKS + BIT_CLKS / 2;
    if (rise_cyc < 0 || lat < mid || lat > mid + 4) begin
      errors++;
      $display("FAIL even_latency: got %0d cycles from start edge, want %0d..%0d", lat, mid, mid + 4);
    end
    checks++;
    comp_lat = lat;
    if ({Data_Rdy, Overrun, Rx_Error, Data_Out} !== {exp_rdy, exp_ovr, exp_err, exp_out}) begin
      errors++;
      $display("FAIL even_A5: got rdy=%b ovr=%b err=%b data=%h, want rdy=%b ovr=%b err=%b data=%h",
               Data_Rdy, Overrun, Rx_Error, Data_Out, exp_rdy, exp_ovr, exp_err, exp_out);
    end
    checks++;
    idle(20);
    do_pop();
    if (Data_Rdy !== 1'b0 || Rx_Busy !== 1'b0) begin
      errors++;
      $display("FAIL even_pop: got rdy=%b busy=%b, want rdy=0 busy=0", Data_Rdy, Rx_Busy);
    end
    checks++;
  endtask

  task automatic test_odd_and_none();
    int lat, mid;
    send_frame(8'hAA, 2'b10, 1'b1, 2'b11, -1, 1'b0);
    model_complete(decode_line(2'b10));
    if ({Data_Rdy, Overrun, Rx_Error, Data_Out} !== {exp_rdy, exp_ovr, exp_err, exp_out}
        || Rx_Error !== 3'b010) begin
      errors++;
      $display("FAIL odd_parity_err: got rdy=%b ovr=%b err=%b data=%h, want rdy=%b ovr=%b err=%b data=%h",
               Data_Rdy, Overrun, Rx_Error, Data_Out, exp_rdy, exp_ovr, exp_err, exp_out);
    end
    checks++;
    idle(20);
    do_pop();
    rise_cyc = -1;
    send_frame(8'h3C, 2'b00, 1'b0, 2'b11, -1, 1'b0);
    model_complete(decode_line(2'b00));
    lat = rise_cyc - frame_start;
    mid = (line_len - 1) * BIT_CLKS + BIT_CLKS / 2;
    if (rise_cyc < 0 || lat < mid || lat > mid + 4) begin
      errors++;
      $display("FAIL none_latency: got %0d cycles from start edge, want %0d..%0d", lat, mid, mid + 4);
    end
    checks++;
    if ({Data_Rdy, Overrun, Rx_Error, Data_Out} !== {exp_rdy, exp_ovr, exp_err, exp_out}) begin
      errors++;
      $display("FAIL none_3C: got rdy=%b ovr=%b err=%b data=%h, want rdy=%b ovr=%b err=%b data=%h",
               Data_Rdy, Overrun, Rx_Error, Data_Out, exp_rdy, exp_ovr, exp_err, exp_out);
    end
    checks++;
    idle(20);
    do_pop();
  endtask

  task automatic test_frame_error();
    send_frame(8'h55, 2'b01, 1'b0, 2'b00, -1, 1'b0);
    model_complete(decode_line(2'b01));
    idle(30);
    if ({Data_Rdy, Overrun, Rx_Error, Data_Out} !== {exp_rdy, exp_ovr, exp_err, exp_out}
        || Rx_Error !== 3'b100) begin
      errors++;
      $display("FAIL frame_err_55: got rdy=%b ovr=%b err=%b data=%h, want rdy=%b ovr=%b err=%b data=%h",
               Data_Rdy, Overrun, Rx_Error, Data_Out, exp_rdy, exp_ovr, exp_err, exp_out);
    end
    checks++;
    do_pop();
  endtask

  task automatic test_break();
    @(negedge Clk);
    Parity_Mode = 2'b01;
    Rx = 1'b0;
    model_complete({3'b001, 8'h00});
    idle(12 * BIT_CLKS + 8);
    if (Rx_Busy !== 1'b1) begin
      errors++;
      $display("FAIL break_wait_busy: got busy=%b, want 1", Rx_Busy);
    end
    checks++;
    if ({Data_Rdy, Overrun, Rx_Error, Data_Out} !== {exp_rdy, exp_ovr, exp_err, exp_out}) begin
      errors++;
      $display("FAIL break_report: got rdy=%b ovr=%b err=%b data=%h, want rdy=%b ovr=%b err=%b data=%h",
               Data_Rdy, Overrun, Rx_Error, Data_Out, exp_rdy, exp_ovr, exp_err, exp_out);
    end
    checks++;
    idle(BIT_CLKS - 8);
    Rx = 1'b1;
    idle(40);
    if ({Data_Rdy, Overrun, Rx_Error, Data_Out, Rx_Busy} !== {exp_rdy, exp_ovr, exp_err, exp_out, 1'b0}) begin
      errors++;
      $display("FAIL break_single: got rdy=%b ovr=%b err=%b data=%h busy=%b, want rdy=%b ovr=%b err=%b data=%h busy=0",
               Data_Rdy, Overrun, Rx_Error, Data_Out, Rx_Busy, exp_rdy, exp_ovr, exp_err, exp_out);
    end
    checks++;
    do_pop();
    send_frame(8'h12, 2'b01, 1'b0, 2'b11, -1, 1'b0);
    model_complete(decode_line(2'b01));
    if ({Data_Rdy, Overrun, Rx_Error, Data_Out} !== {exp_rdy, exp_ovr, exp_err, exp_out}) begin
      errors++;
      $display("FAIL after_break_12: got rdy=%b ovr=%b err=%b data=%h, want rdy=%b ovr=%b err=%b data=%h",
               Data_Rdy, Overrun, Rx_Error, Data_Out, exp_rdy, exp_ovr, exp_err, exp_out);
    end
    checks++;
    idle(20);
    do_pop();
  endtask

  task automatic test_glitch();
    int n;
    @(negedge Clk);
    Rx = 1'b0;
    idle(4);
    Rx = 1'b1;
    for (int i = 0; i < 10 && !Rx_Busy; i++) @(negedge Clk);
    if (Rx_Busy !== 1'b1) begin
      errors++;
      $display("FAIL glitch_start: got busy=%b after start edge, want 1", Rx_Busy);
    end
    checks++;
    n = 1;
    while (Rx_Busy && n < 40) begin
      @(negedge Clk);
      if (Rx_Busy) n++;
    end
    if (n > 8) begin
      errors++;
      $display("FAIL glitch_busy_len: got busy for %0d cycles, want at most 8", n);
    end
    checks++;
    idle(30);
    if (Data_Rdy !== 1'b0 || Rx_Busy !== 1'b0) begin
      errors++;
      $display("FAIL glitch_no_word: got rdy=%b busy=%b, want rdy=0 busy=0", Data_Rdy, Rx_Busy);
    end
    checks++;
  endtask

  task automatic test_rst_mid();
    send_frame(8'h5A, 2'b00, 1'b0, 2'b11, -1, 1'b0);
    model_complete(decode_line(2'b00));
    idle(20);
    send_frame(8'hC3, 2'b00, 1'b0, 2'b11, 5, 1'b1);
    exp_out = '0; exp_err = '0; exp_rdy = 1'b0; exp_ovr = 1'b0;
    idle(20);
    if ({Data_Rdy, Overrun, Rx_Error, Data_Out, Rx_Busy} !== {exp_rdy, exp_ovr, exp_err, exp_out, 1'b0}) begin
      errors++;
      $display("FAIL rst_mid_frame: got rdy=%b ovr=%b err=%b data=%h busy=%b, want all zero",
               Data_Rdy, Overrun, Rx_Error, Data_Out, Rx_Busy);
    end
    checks++;
    send_frame(8'h96, 2'b01, 1'b0, 2'b11, -1, 1'b0);
    model_complete(decode_line(2'b01));
    if ({Data_Rdy, Overrun, Rx_Error, Data_Out} !== {exp_rdy, exp_ovr, exp_err, exp_out}) begin
      errors++;
      $display("FAIL after_rst_96: got rdy=%b ovr=%b err=%b data=%h, want rdy=%b ovr=%b err=%b data=%h",
               Data_Rdy, Overrun, Rx_Error, Data_Out, exp_rdy, exp_ovr, exp_err, exp_out);
    end
    checks++;
    idle(20);
    do_pop();
  endtask

  task automatic test_en_abort();
    send_frame(8'h3E, 2'b01, 1'b0, 2'b11, -1, 1'b0);
    model_complete(decode_line(2'b01));
    idle(20);
    send_frame(8'hF0, 2'b01, 1'b0, 2'b11, 4, 1'b0);
    idle(20);
    if ({Data_Rdy, Overrun, Rx_Error, Data_Out, Rx_Busy} !== {exp_rdy, exp_ovr, exp_err, exp_out, 1'b0}) begin
      errors++;
      $display("FAIL en_abort_keep: got rdy=%b ovr=%b err=%b data=%h busy=%b, want rdy=%b ovr=%b err=%b data=%h busy=0",
               Data_Rdy, Overrun, Rx_Error, Data_Out, Rx_Busy, exp_rdy, exp_ovr, exp_err, exp_out);
    end
    checks++;
    Rx_En = 1'b1;
    idle(10);
    do_pop();
  endtask

  task automatic test_overrun();
    logic [7:0] w;
    send_frame(8'h01, 2'b01, 1'b0, 2'b11, -1, 1'b0);
    model_complete(decode_line(2'b01));
    idle(20);
    send_frame(8'h02, 2'b01, 1'b0, 2'b11, -1, 1'b0);
    model_complete(decode_line(2'b01));
    idle(20);
    if ({Data_Rdy, Overrun, Rx_Error, Data_Out} !== {exp_rdy, exp_ovr, exp_err, exp_out}) begin
      errors++;
      $display("FAIL overrun_set: got rdy=%b ovr=%b err=%b data=%h, want rdy=%b ovr=%b err=%b data=%h",
               Data_Rdy, Overrun, Rx_Error, Data_Out, exp_rdy, exp_ovr, exp_err, exp_out);
    end
    checks++;
    do_pop();
    if (Data_Rdy !== exp_rdy || Overrun !== exp_ovr) begin
      errors++;
      $display("FAIL overrun_pop: got rdy=%b ovr=%b, want rdy=%b ovr=%b", Data_Rdy, Overrun, exp_rdy, exp_ovr);
    end
    checks++;
    w = 8'($urandom_range(0, 255));
    send_frame(w, 2'b01, 1'b0, 2'b11, -1, 1'b0);
    model_complete(decode_line(2'b01));
    idle(20);
    if (comp_lat <= 0) comp_lat = 11 * BIT_CLKS + BIT_CLKS / 2 + 3;
    fork
      send_frame(8'h03, 2'b01, 1'b0, 2'b11, -1, 1'b0);
      begin
        @(negedge Clk);
        repeat (comp_lat - 1) @(negedge Clk);
        Pop_Data = 1'b1;
        @(negedge Clk);
        Pop_Data = 1'b0;
      end
    join
    exp_out = 8'h03; exp_err = 3'b000; exp_rdy = 1'b1; exp_ovr = 1'b0;
    if ({Data_Rdy, Overrun, Rx_Error, Data_Out} !== {exp_rdy, exp_ovr, exp_err, exp_out}) begin
      errors++;
      $display("FAIL pop_on_completion: got rdy=%b ovr=%b err=%b data=%h, want rdy=%b ovr=%b err=%b data=%h",
               Data_Rdy, Overrun, Rx_Error, Data_Out, exp_rdy, exp_ovr, exp_err, exp_out);
    end
    checks++;
    idle(20);
    do_pop();
  endtask

  task automatic test_random();
    logic [7:0] d;
    logic [1:0] mode, stops;
    bit flip;
    int lat, mid;
    for (int k = 0; k < 10; k++) begin
      d     = 8'($urandom_range(0, 255));
      mode  = 2'($urandom_range(0, 3));
      flip  = 1'($urandom_range(0, 1));
      stops = 2'($urandom_range(0, 3));
      rise_cyc = -1;
      send_frame(d, mode, flip, stops, -1, 1'b0);
      model_complete(decode_line(mode));
      lat = rise_cyc - frame_start;
      mid = (line_len - 1) * BIT_CLKS + BIT_CLKS / 2;
      if (rise_cyc < 0 || lat < mid || lat > mid + 4) begin
        errors++;
        $display("FAIL rand_latency[%0d]: got %0d cycles, want %0d..%0d", k, lat, mid, mid + 4);
      end
      checks++;
      idle(30);
      if ({Data_Rdy, Overrun, Rx_Error, Data_Out} !== {exp_rdy, exp_ovr, exp_err, exp_out}) begin
        errors++;
        $display("FAIL rand_frame[%0d] d=%h mode=%b flip=%0d stops=%b: got rdy=%b ovr=%b err=%b data=%h, want rdy=%b ovr=%b err=%b data=%h",
                 k, d, mode, flip, stops, Data_Rdy, Overrun, Rx_Error, Data_Out,
                 exp_rdy, exp_ovr, exp_err, exp_out);
      end
      checks++;
      do_pop();
      if (Data_Rdy !== 1'b0) begin
        errors++;
        $display("FAIL rand_pop[%0d]: got rdy=%b, want 0", k, Data_Rdy);
      end
      checks++;
    end
  endtask

  initial begin
    test_reset();
    test_even_parity();
    test_odd_and_none();
    test_frame_error();
    test_break();
    test_glitch();
    test_rst_mid();
    test_en_abort();
    test_overrun();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
